// File: rtl/sev_seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Digit count, BCD nibble type and scan FSM states.
package sev_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// Display image load port: valid/ready handshake
// carrying an 8-digit BCD image and digit enable mask.
interface sev_seg_scan_ctrl_if;
  import sev_seg_pkg::*;

  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic [NUM_DIGITS-1:0]     load_mask;

  modport master (
    output load_valid,
    output load_data,
    output load_mask,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_mask,
    output load_ready
  );

endinterface

// File: rtl/sev_seg_lzb.sv
// Leading-zero blanking: flags digits 7..1 that sit in
// an all-zero run reaching the leftmost digit.
module sev_seg_lzb
  import sev_seg_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] img,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   blank
);

  logic run;

  // digit 0 is never blanked so an all-zero image shows "0"
  always_comb begin
    blank = '0;
    run   = lzb_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run      = run & (img[4*i +: 4] == bcd_t'(0));
      blank[i] = run;
    end
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed 8-digit display scanner with double-buffered
// image, anti-ghost guard interval and leading-zero blanking.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  sev_seg_scan_ctrl_if.slave    load,
  input  logic                  lzb_en,
  output logic [2:0]            digit_sel,
  output bcd_t                  digit_bcd,
  output logic                  digit_on,
  output logic                  frame_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST =
    CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam scan_state_t SLOT_START =
    (GUARD_CYC == 0) ? DRIVE : GUARD;

  logic [4*NUM_DIGITS-1:0] shadow_img, active_img;
  logic [4*NUM_DIGITS-1:0] active_img_d;
  logic [NUM_DIGITS-1:0]   shadow_mask, active_mask;
  logic [NUM_DIGITS-1:0]   active_mask_d;
  logic                    pending, pending_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [2:0]              idx, idx_d;
  scan_state_t             state, state_d;
  logic                    wrap, commit, accept;
  logic [NUM_DIGITS-1:0]   blank;

  assign load.load_ready = !pending;
  assign accept = load.load_valid & !pending;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
          idx_d   = '0;
        end
        GUARD: begin
          cnt_d = cnt + CW'(1);
          if (cnt == GUARD_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt == TICK_LAST) begin
            cnt_d   = '0;
            idx_d   = idx + 3'd1;
            state_d = SLOT_START;
            wrap    = (idx == 3'd7);
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // swap buffers only between frames so a frame never tears
  assign commit = pending & (wrap | (state == IDLE));
  assign active_img_d  = commit ? shadow_img : active_img;
  assign active_mask_d = commit ? shadow_mask : active_mask;
  assign pending_d = accept | (pending & !commit);

  sev_seg_lzb u_lzb (
    .img    (active_img_d),
    .lzb_en (lzb_en),
    .blank  (blank)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_img  <= '0;
      shadow_mask <= '0;
      active_img  <= '0;
      active_mask <= '0;
      pending     <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      state       <= IDLE;
      digit_sel   <= '0;
      digit_bcd   <= '0;
      digit_on    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (accept) begin
        shadow_img  <= load.load_data;
        shadow_mask <= load.load_mask;
      end
      active_img  <= active_img_d;
      active_mask <= active_mask_d;
      pending     <= pending_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      state       <= state_d;
      digit_sel   <= idx_d;
      digit_bcd   <= (state_d == IDLE) ? bcd_t'(0)
                   : active_img_d[{idx_d, 2'b00} +: 4];
      digit_on    <= (state_d == DRIVE)
                   & active_mask_d[idx_d] & !blank[idx_d];
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl: directed scenarios plus random
// traffic checked every cycle against a time-based model.
module tb_sev_seg_scan_ctrl;

  localparam int TD = 10;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       lzb;
  logic [2:0] sel;
  logic [3:0] bcd;
  logic       on;
  logic       fd;

  int checks = 0;
  int errors = 0;

  bit          m_scan;
  int          m_t;
  bit          m_pending;
  bit          m_accepted;
  logic [31:0] m_shadow, m_active;
  logic [7:0]  m_smask, m_amask;

  sev_seg_scan_ctrl_if lif ();

  sev_seg_scan_ctrl #(
    .TICK_DIV  (TD),
    .GUARD_CYC (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (en),
    .load       (lif),
    .lzb_en     (lzb),
    .digit_sel  (sel),
    .digit_bcd  (bcd),
    .digit_on   (on),
    .frame_done (fd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan    = 0;
    m_t       = 0;
    m_pending = 0;
    m_shadow  = '0;
    m_active  = '0;
    m_smask   = '0;
    m_amask   = '0;
  endtask

  task automatic check_outputs();
    int  slot, ph;
    bit  blk;
    logic [31:0] e_sel, e_bcd, e_on, e_fd;
    if (!m_scan) begin
      e_sel = 0; e_bcd = 0; e_on = 0; e_fd = 0;
    end else begin
      slot  = (m_t / TD) % 8;
      ph    = m_t % TD;
      e_sel = slot;
      e_bcd = (m_active >> (4 * slot)) & 32'hf;
      blk   = lzb && slot > 0 &&
              ((m_active >> (4 * slot)) == 0);
      e_on  = (ph >= GC && m_amask[slot] && !blk) ? 1 : 0;
      e_fd  = (m_t > 0 && m_t % (8 * TD) == 0) ? 1 : 0;
    end
    chk("digit_sel", 32'(sel), e_sel);
    chk("digit_bcd", 32'(bcd), e_bcd);
    chk("digit_on", 32'(on), e_on);
    chk("frame_done", 32'(fd), e_fd);
    chk("load_ready", 32'(lif.load_ready),
        32'(!m_pending));
  endtask

  task automatic step();
    bit acc, wrap;
    @(posedge clk);
    acc  = lif.load_valid && !m_pending;
    wrap = m_scan && en && (m_t % (8 * TD) == 8 * TD - 1);
    m_accepted = acc;
    if (m_pending && (!m_scan || wrap)) begin
      m_active  = m_shadow;
      m_amask   = m_smask;
      m_pending = 0;
    end
    if (acc) begin
      m_shadow  = lif.load_data;
      m_smask   = lif.load_mask;
      m_pending = 1;
    end
    if (!en) begin
      m_scan = 0;
      m_t    = 0;
    end else if (!m_scan) begin
      m_scan = 1;
      m_t    = 0;
    end else begin
      m_t++;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [31:0] d,
                      input logic [7:0] m);
    int waited = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_mask  = m;
    m_accepted = 0;
    while (!m_accepted && waited < 200) begin
      step();
      waited++;
    end
    lif.load_valid = 1'b0;
    if (!m_accepted) begin
      checks++;
      errors++;
      $error("FAIL load_wait: observed no accept expected accept");
    end
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    lzb = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_mask  = '0;
    model_reset();
    #2 rst = 1'b0;
    #2 check_outputs();
    #8 rst = 1'b1;

    run(3);
    load(32'h8765_4321, 8'hFF);
    en = 1'b1;
    run(170);

    run(35);
    load(32'h1111_1111, 8'h0F);
    load(32'h2222_2222, 8'hF0);
    run(100);

    lzb = 1'b1;
    load(32'h0000_0450, 8'hFF);
    run(170);
    load(32'h0000_0000, 8'hFF);
    run(170);
    lzb = 1'b0;

    load(32'h1234_5678, 8'h0F);
    run(170);

    begin
      int w = 0;
      while (!(m_scan && (m_t / TD) % 8 == 5 &&
               m_t % TD >= GC + 1) && w < 200) begin
        step();
        w++;
      end
      if (w >= 200) begin
        checks++;
        errors++;
        $error("FAIL drive5_wait: observed timeout expected slot 5");
      end
    end
    en = 1'b0;
    step();
    en = 1'b1;
    run(30);

    run(33);
    load(32'h9999_9999, 8'hFF);
    run(3);
    pulse_reset();
    run(100);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) en = ~en;
      if ($urandom_range(99) == 0) lzb = ~lzb;
      lif.load_valid = ($urandom_range(15) == 0);
      lif.load_data  = $urandom >> (4 * $urandom_range(8));
      lif.load_mask  = 8'($urandom);
      if ($urandom_range(999) == 0) pulse_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
